map_dscr_bx: RTL and testbench

- Parametrised discrete-logic bank-switching mapper. Successor to the single-purpose BxROM/NINA-001 mapper.
- Supports four modes, selected by parameter:
  - BxROM
  - NINA-001
  - AxROM (32K PRG, 1-screen mirroring)
  - GxROM
- Adds an AUTO mode. In AUTO, the first register write locks BxROM or NINA-001 decoding.
- Sits in the mapper slot between the cart bus and the PRG/CHR/SRAM/CIRAM address and strobe outputs. Full save-state access.

---
 rtl/map_dscr_bx_if.sv | 45 ++++
 rtl/map_dscr_bx.sv | 184 ++++++++++++++++++
 tb/tb_map_dscr_bx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_dscr_bx_if.sv
// Cart-side bus bundle for map_dscr_bx: CPU bus, PPU bus, configuration
// straps, save-state port and the mapped PRG/CHR/SRAM/CIRAM outputs.
// The mapper attaches through the slave modport; the cart/host side uses master.
interface map_dscr_bx_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic        cpu_ce;
  logic [7:0]  prg_dat;
  logic [13:0] ppu_addr;
  logic        ppu_oe;
  logic        ppu_we;
  logic        cfg_chr_ram;
  logic        cfg_mir_v;
  logic        ss_act;
  logic        ss_we;
  logic [7:0]  ss_addr;

  logic [22:0] prg_addr;
  logic [19:0] chr_addr;
  logic        rom_ce;
  logic        ram_ce;
  logic        ram_we;
  logic        chr_ce;
  logic        chr_we;
  logic        ciram_ce;
  logic        ciram_a10;
  logic [7:0]  ss_rdat;

  modport slave (
    input  cpu_addr, cpu_dat, cpu_rw, cpu_ce, prg_dat,
    input  ppu_addr, ppu_oe, ppu_we, cfg_chr_ram, cfg_mir_v,
    input  ss_act, ss_we, ss_addr,
    output prg_addr, chr_addr, rom_ce, ram_ce, ram_we,
    output chr_ce, chr_we, ciram_ce, ciram_a10, ss_rdat
  );

  modport master (
    output cpu_addr, cpu_dat, cpu_rw, cpu_ce, prg_dat,
    output ppu_addr, ppu_oe, ppu_we, cfg_chr_ram, cfg_mir_v,
    output ss_act, ss_we, ss_addr,
    input  prg_addr, chr_addr, rom_ce, ram_ce, ram_we,
    input  chr_ce, chr_we, ciram_ce, ciram_a10, ss_rdat
  );
endinterface

// File: rtl/map_dscr_bx.sv
// Discrete-logic bank-switching mapper: BxROM, NINA-001, AxROM, GxROM, or
// AUTO (first register write locks BxROM or NINA-001 decoding).
// State updates on the falling edge of M2; map_rst clears everything async.
// Optional feature macro: BUS_CONFLICT_EN (AND write data with ROM data on
// $8000+ writes in the discrete-latch modes).
module map_dscr_bx #(
  parameter int unsigned PRG_BW  = 4,
  parameter int unsigned CHR_BW  = 5,
  parameter int unsigned MODE    = 4,
  parameter int unsigned MAP_IDX = 34
) (
  input  logic          m2,
  input  logic          map_rst,
  map_dscr_bx_if.slave  bus
);

  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_BX   = 2'd1,
    LK_NINA = 2'd2
  } lock_e;

  typedef enum logic [1:0] {
    M_BX   = 2'd0,
    M_NINA = 2'd1,
    M_AX   = 2'd2,
    M_GX   = 2'd3
  } mode_e;

  logic [PRG_BW-1:0] prg_q, prg_d;
  logic [CHR_BW-1:0] chr0_q, chr0_d;
  logic [CHR_BW-1:0] chr1_q, chr1_d;
  logic              mir_q, mir_d;
  lock_e             lock_q, lock_d, lock_bus;

  mode_e       rd_mode;
  mode_e       wr_mode;
  logic        bus_wr;
  logic        nina_reg;
  logic [7:0]  wdat;
  logic        chr_ram_eff;

  assign bus_wr   = !bus.cpu_rw && !bus.ss_act;
  assign nina_reg = (bus.cpu_addr[15:2] == 14'h1FFF) && (bus.cpu_addr[1:0] != 2'b00);

  // Lock transition caused by the current bus write (AUTO only)
  always_comb begin
    lock_bus = lock_q;
    if (MODE == 4 && bus_wr && lock_q == LK_IDLE) begin
      if (bus.cpu_addr[15])
        lock_bus = LK_BX;
      else if (nina_reg)
        lock_bus = LK_NINA;
    end
  end

  // Decode modes: the locking write is already decoded in its new mode
  always_comb begin
    if (MODE < 4) begin
      rd_mode = mode_e'(MODE[1:0]);
      wr_mode = mode_e'(MODE[1:0]);
    end else begin
      rd_mode = (lock_q == LK_NINA) ? M_NINA : M_BX;
      wr_mode = (lock_bus == LK_NINA) ? M_NINA : M_BX;
    end
  end

  // Effective write data (bus conflicts only in the discrete-latch modes)
  always_comb begin
`ifdef BUS_CONFLICT_EN
    wdat = (wr_mode != M_NINA && bus.cpu_addr[15]) ? (bus.cpu_dat & bus.prg_dat) : bus.cpu_dat;
`else
    wdat = bus.cpu_dat;
`endif
  end

  // Next-state: save-state access has priority over bus writes
  always_comb begin
    prg_d  = prg_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    mir_d  = mir_q;
    lock_d = lock_q;
    if (bus.ss_act) begin
      if (bus.ss_we) begin
        case (bus.ss_addr)
          8'd0:    prg_d  = PRG_BW'(bus.cpu_dat);
          8'd1:    chr0_d = CHR_BW'(bus.cpu_dat);
          8'd2:    chr1_d = CHR_BW'(bus.cpu_dat);
          8'd3: begin
            lock_d = lock_e'(bus.cpu_dat[5:4]);
            mir_d  = bus.cpu_dat[0];
          end
          default: ;
        endcase
      end
    end else if (!bus.cpu_rw) begin
      lock_d = lock_bus;
      case (wr_mode)
        M_BX: if (bus.cpu_addr[15]) prg_d = PRG_BW'(wdat);
        M_NINA: begin
          case (bus.cpu_addr)
            16'h7FFD: prg_d  = PRG_BW'(wdat);
            16'h7FFE: chr0_d = CHR_BW'(wdat);
            16'h7FFF: chr1_d = CHR_BW'(wdat);
            default:  ;
          endcase
        end
        M_AX: if (bus.cpu_addr[15]) begin
          prg_d = PRG_BW'(wdat[2:0]);
          mir_d = wdat[4];
        end
        M_GX: if (bus.cpu_addr[15]) begin
          prg_d  = PRG_BW'(wdat[5:4]);
          chr0_d = CHR_BW'(wdat[1:0]);
        end
        default: ;
      endcase
    end
  end

  // Bank, mirroring and lock registers, committed on falling M2
  always_ff @(negedge m2 or posedge map_rst) begin
    if (map_rst) begin
      prg_q  <= '0;
      chr0_q <= '0;
      chr1_q <= '0;
      mir_q  <= 1'b0;
      lock_q <= LK_IDLE;
    end else begin
      prg_q  <= prg_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      mir_q  <= mir_d;
      lock_q <= lock_d;
    end
  end

  // PRG / SRAM address and strobes
  always_comb begin
    bus.prg_addr = {(bus.cpu_ce ? 8'h00 : 8'(prg_q)), bus.cpu_addr[14:0]};
    bus.rom_ce   = !bus.cpu_ce;
    bus.ram_ce   = (bus.cpu_addr[15:13] == 3'b011);
    bus.ram_we   = (bus.cpu_addr[15:13] == 3'b011) && !bus.cpu_rw;
  end

  // CHR address, PPU strobes and nametable select
  always_comb begin
    case (rd_mode)
      M_NINA:  bus.chr_addr = bus.cfg_chr_ram ? 20'(bus.ppu_addr[12:0])
                            : {(bus.ppu_addr[12] ? 8'(chr1_q) : 8'(chr0_q)), bus.ppu_addr[11:0]};
      M_GX:    bus.chr_addr = 20'({chr0_q, bus.ppu_addr[12:0]});
      default: bus.chr_addr = 20'(bus.ppu_addr[12:0]);
    endcase
    // BxROM and AxROM boards always carry CHR RAM
    chr_ram_eff   = bus.cfg_chr_ram || rd_mode == M_BX || rd_mode == M_AX;
    bus.chr_ce    = !bus.ppu_addr[13];
    bus.ciram_ce  = !bus.ppu_addr[13];
    bus.chr_we    = chr_ram_eff && !bus.ppu_we && !bus.ppu_addr[13];
    bus.ciram_a10 = (rd_mode == M_AX) ? mir_q
                  : (bus.cfg_mir_v ? bus.ppu_addr[10] : bus.ppu_addr[11]);
  end

  // Save-state read-back
  always_comb begin
    case (bus.ss_addr)
      8'd0:    bus.ss_rdat = 8'(prg_q);
      8'd1:    bus.ss_rdat = 8'(chr0_q);
      8'd2:    bus.ss_rdat = 8'(chr1_q);
      8'd3:    bus.ss_rdat = {2'b00, lock_q, 3'b000, mir_q};
      8'd127:  bus.ss_rdat = 8'(MAP_IDX);
      default: bus.ss_rdat = 8'hFF;
    endcase
  end

  // Inputs this mapper has no use for in the current build
  logic unused_ok;
`ifdef BUS_CONFLICT_EN
  assign unused_ok = &{1'b0, bus.ppu_oe};
`else
  assign unused_ok = &{1'b0, bus.ppu_oe, bus.prg_dat};
`endif

endmodule

// File: tb/tb_map_dscr_bx.sv
// Directed bench for map_dscr_bx: one instance per MODE (0..4) sharing the
// same stimulus; a vector table plus hand sequences for save-state, lock,
// double-write, async reset, strobes and bus conflicts.
module tb_map_dscr_bx;

  logic        m2 = 1'b0;
  logic        map_rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw, cpu_ce;
  logic [7:0]  prg_dat;
  logic [13:0] ppu_addr;
  logic        ppu_oe, ppu_we, cfg_chr_ram, cfg_mir_v;
  logic        ss_act, ss_we;
  logic [7:0]  ss_addr;

  logic [22:0] prg_addr_a [5];
  logic [19:0] chr_addr_a [5];
  logic [7:0]  ss_rdat_a  [5];
  logic        rom_ce_a [5], ram_ce_a [5], ram_we_a [5];
  logic        chr_ce_a [5], chr_we_a [5], ciram_ce_a [5], a10_a [5];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #10 m2 = ~m2;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    map_dscr_bx_if u_if ();
    assign u_if.cpu_addr    = cpu_addr;
    assign u_if.cpu_dat     = cpu_dat;
    assign u_if.cpu_rw      = cpu_rw;
    assign u_if.cpu_ce      = cpu_ce;
    assign u_if.prg_dat     = prg_dat;
    assign u_if.ppu_addr    = ppu_addr;
    assign u_if.ppu_oe      = ppu_oe;
    assign u_if.ppu_we      = ppu_we;
    assign u_if.cfg_chr_ram = cfg_chr_ram;
    assign u_if.cfg_mir_v   = cfg_mir_v;
    assign u_if.ss_act      = ss_act;
    assign u_if.ss_we       = ss_we;
    assign u_if.ss_addr     = ss_addr;
    assign prg_addr_a[g] = u_if.prg_addr;
    assign chr_addr_a[g] = u_if.chr_addr;
    assign ss_rdat_a[g]  = u_if.ss_rdat;
    assign rom_ce_a[g]   = u_if.rom_ce;
    assign ram_ce_a[g]   = u_if.ram_ce;
    assign ram_we_a[g]   = u_if.ram_we;
    assign chr_ce_a[g]   = u_if.chr_ce;
    assign chr_we_a[g]   = u_if.chr_we;
    assign ciram_ce_a[g] = u_if.ciram_ce;
    assign a10_a[g]      = u_if.ciram_a10;

    map_dscr_bx #(.PRG_BW(4), .CHR_BW(5), .MODE(g), .MAP_IDX(34)) u_dut (
      .m2      (m2),
      .map_rst (map_rst),
      .bus     (u_if)
    );
  end

  typedef struct {
    bit          rst;
    int unsigned dut;
    bit          wr;
    logic [15:0] waddr;
    logic [7:0]  wdat;
    logic [15:0] raddr;
    logic [13:0] ppa;
    logic        chr_ram;
    logic        mir_v;
    logic [22:0] e_prg;
    logic [19:0] e_chr;
    logic        e_a10;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge m2);
    #2 map_rst = 1'b1;
    #4 map_rst = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge m2);
    #1;
    cpu_addr = a;
    cpu_dat  = d;
    cpu_ce   = ~a[15];
    cpu_rw   = 1'b0;
    @(negedge m2);
    #1 cpu_rw = 1'b1;
  endtask

  task automatic ss_write(input logic [7:0] idx, input logic [7:0] d);
    @(posedge m2);
    #1;
    ss_addr = idx;
    cpu_dat = d;
    ss_we   = 1'b1;
    @(negedge m2);
    #1 ss_we = 1'b0;
  endtask

  task automatic ss_chk(input int unsigned d, input logic [7:0] idx,
                        input logic [7:0] exp, input string nm);
    ss_addr = idx;
    #1;
    chk(nm, 32'(ss_rdat_a[d]), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    map_rst = 1'b1; cpu_addr = 16'h0000; cpu_dat = 8'h00; cpu_rw = 1'b1;
    cpu_ce = 1'b1;  prg_dat = 8'hFF;     ppu_addr = 14'h0000; ppu_oe = 1'b1;
    ppu_we = 1'b1;  cfg_chr_ram = 1'b0;  cfg_mir_v = 1'b1;
    ss_act = 1'b0;  ss_we = 1'b0;        ss_addr = 8'd0;

    //        rst dut wr waddr     wdat   raddr     ppa       cr mv e_prg        e_chr       a10
    vt[0]  = '{1, 0, 1, 16'h8000, 8'h03, 16'hC123, 14'h0100, 0, 1, 23'h1C123, 20'h00100, 1'b0};
    vt[1]  = '{0, 0, 0, 16'h0000, 8'h00, 16'h6010, 14'h0400, 0, 1, 23'h06010, 20'h00400, 1'b1};
    vt[2]  = '{0, 0, 0, 16'h0000, 8'h00, 16'h8000, 14'h0400, 0, 0, 23'h18000, 20'h00400, 1'b0};
    vt[3]  = '{0, 0, 1, 16'h8000, 8'hFF, 16'hFFFF, 14'h0800, 0, 0, 23'h7FFFF, 20'h00800, 1'b1};
    vt[4]  = '{1, 1, 1, 16'h7FFE, 8'h05, 16'h8000, 14'h0100, 0, 1, 23'h00000, 20'h05100, 1'b0};
    vt[5]  = '{0, 1, 1, 16'h7FFF, 8'h0A, 16'h8000, 14'h1100, 0, 1, 23'h00000, 20'h0A100, 1'b0};
    vt[6]  = '{0, 1, 0, 16'h0000, 8'h00, 16'h8000, 14'h0100, 0, 1, 23'h00000, 20'h05100, 1'b0};
    vt[7]  = '{0, 1, 1, 16'h7FFD, 8'h13, 16'h8000, 14'h1100, 1, 1, 23'h18000, 20'h01100, 1'b0};
    vt[8]  = '{0, 1, 1, 16'h7FFE, 8'h25, 16'h8000, 14'h0FFF, 0, 1, 23'h18000, 20'h05FFF, 1'b1};
    vt[9]  = '{1, 2, 1, 16'h8000, 8'h15, 16'h8000, 14'h0000, 0, 1, 23'h28000, 20'h00000, 1'b1};
    vt[10] = '{0, 2, 0, 16'h0000, 8'h00, 16'h8000, 14'h0800, 0, 1, 23'h28000, 20'h00800, 1'b1};
    vt[11] = '{0, 2, 1, 16'h8000, 8'h0E, 16'h8000, 14'h0C00, 0, 1, 23'h30000, 20'h00C00, 1'b0};
    vt[12] = '{1, 3, 1, 16'h8000, 8'h32, 16'h8000, 14'h0123, 0, 1, 23'h18000, 20'h04123, 1'b0};
    vt[13] = '{1, 4, 1, 16'h7FFD, 8'h02, 16'h8000, 14'h0100, 0, 1, 23'h10000, 20'h00100, 1'b0};
    vt[14] = '{0, 4, 1, 16'h8000, 8'h07, 16'h8000, 14'h0100, 0, 1, 23'h10000, 20'h00100, 1'b0};
    vt[15] = '{0, 4, 1, 16'h7FFE, 8'h06, 16'h8000, 14'h0100, 0, 1, 23'h10000, 20'h06100, 1'b0};
    vt[16] = '{1, 4, 1, 16'h8000, 8'h04, 16'h8000, 14'h0100, 0, 1, 23'h20000, 20'h00100, 1'b0};
    vt[17] = '{0, 4, 1, 16'h7FFE, 8'h06, 16'h8000, 14'h0100, 0, 1, 23'h20000, 20'h00100, 1'b0};

    // Reset state, observed while map_rst is still high
    #1;
    for (int unsigned r = 0; r < 4; r++)
      ss_chk(4, 8'(r), 8'h00, $sformatf("reset ss%0d", r));
    ss_chk(4, 8'd127, 8'h22, "ss map_idx");
    ss_chk(4, 8'd50,  8'hFF, "ss unmapped 50");
    ss_chk(4, 8'd4,   8'hFF, "ss unmapped 4");
    #20 map_rst = 1'b0;

    // Vector table
    for (int i = 0; i < 18; i++) begin
      if (vt[i].rst) do_reset();
      if (vt[i].wr) bus_write(vt[i].waddr, vt[i].wdat);
      cpu_addr    = vt[i].raddr;
      cpu_ce      = ~vt[i].raddr[15];
      cpu_rw      = 1'b1;
      ppu_addr    = vt[i].ppa;
      cfg_chr_ram = vt[i].chr_ram;
      cfg_mir_v   = vt[i].mir_v;
      #2;
      chk($sformatf("v%0d prg_addr", i), 32'(prg_addr_a[vt[i].dut]), 32'(vt[i].e_prg));
      chk($sformatf("v%0d chr_addr", i), 32'(chr_addr_a[vt[i].dut]), 32'(vt[i].e_chr));
      chk($sformatf("v%0d ciram_a10", i), 32'(a10_a[vt[i].dut]), 32'(vt[i].e_a10));
    end
    cfg_chr_ram = 1'b0;
    cfg_mir_v   = 1'b1;

    // AUTO lock readback and release by reset
    do_reset();
    bus_write(16'h7FFD, 8'h02);
    ss_chk(4, 8'd3, 8'h20, "auto lock nina");
    ss_chk(4, 8'd0, 8'h02, "auto lock prg");
    do_reset();
    ss_chk(4, 8'd3, 8'h00, "auto lock idle after rst");

    // Save-state writes block bus writes and lock transitions
    do_reset();
    ss_act = 1'b1;
    ss_write(8'd0, 8'h09);
    bus_write(16'h8000, 8'h01);
    ss_write(8'd3, 8'h11);
    ss_write(8'd1, 8'h3F);
    ss_write(8'd60, 8'h55);
    ss_act = 1'b0;
    ss_chk(0, 8'd0, 8'h09, "ss prg blocks bus");
    ss_chk(4, 8'd3, 8'h11, "ss lock/mir");
    ss_chk(4, 8'd1, 8'h1F, "ss chr0 wrap");
    ss_chk(4, 8'd2, 8'h00, "ss chr1 untouched");
    cpu_addr = 16'h8000; cpu_ce = 1'b0; ppu_addr = 14'h0000;
    #1;
    chk("ss prg_addr", 32'(prg_addr_a[0]), 32'h48000);
    chk("ss ax mir", 32'(a10_a[2]), 32'h1);
    bus_write(16'h7FFD, 8'h03);
    ss_chk(4, 8'd0, 8'h09, "restored bx ignores 7ffd");
    ss_chk(1, 8'd0, 8'h03, "nina 7ffd after ss");

    // Consecutive-cycle double write: both commit, last wins
    do_reset();
    ss_addr = 8'd0;
    @(posedge m2);
    #1 cpu_addr = 16'h8000; cpu_ce = 1'b0; cpu_dat = 8'h05; cpu_rw = 1'b0;
    @(negedge m2);
    #1 chk("rmw first", 32'(ss_rdat_a[0]), 32'h05);
    cpu_dat = 8'h06;
    @(negedge m2);
    #1 chk("rmw second", 32'(ss_rdat_a[0]), 32'h06);
    cpu_rw = 1'b1;

    // Async reset clears state without waiting for an M2 edge
    @(posedge m2);
    #3 map_rst = 1'b1;
    #1;
    chk("async rst prg", 32'(ss_rdat_a[0]), 32'h00);
    chk("async rst prg_addr", 32'(prg_addr_a[0]), 32'h00000);
    #1 map_rst = 1'b0;

    // PRG/SRAM and PPU strobes
    @(posedge m2);
    #1 cpu_addr = 16'h6000; cpu_ce = 1'b1; cpu_rw = 1'b0;
    #1;
    chk("ram_ce 6000", 32'(ram_ce_a[0]), 32'h1);
    chk("ram_we 6000", 32'(ram_we_a[0]), 32'h1);
    chk("rom_ce 6000", 32'(rom_ce_a[0]), 32'h0);
    cpu_rw = 1'b1; cpu_addr = 16'h5FFF;
    #1 chk("ram_ce 5fff", 32'(ram_ce_a[0]), 32'h0);
    cpu_addr = 16'h7FFF;
    #1;
    chk("ram_ce 7fff", 32'(ram_ce_a[0]), 32'h1);
    chk("ram_we read", 32'(ram_we_a[0]), 32'h0);
    cpu_addr = 16'h8000; cpu_ce = 1'b0;
    #1;
    chk("rom_ce 8000", 32'(rom_ce_a[0]), 32'h1);
    chk("ram_ce 8000", 32'(ram_ce_a[0]), 32'h0);
    ppu_addr = 14'h0100; ppu_we = 1'b0; cfg_chr_ram = 1'b0;
    #1;
    chk("chr_we nina rom", 32'(chr_we_a[1]), 32'h0);
    chk("chr_we bx forced", 32'(chr_we_a[0]), 32'h1);
    chk("chr_ce low", 32'(chr_ce_a[1]), 32'h1);
    cfg_chr_ram = 1'b1;
    #1 chk("chr_we nina ram", 32'(chr_we_a[1]), 32'h1);
    ppu_addr = 14'h2000;
    #1;
    chk("chr_ce nt", 32'(chr_ce_a[1]), 32'h0);
    chk("ciram_ce nt", 32'(ciram_ce_a[1]), 32'h0);
    chk("chr_we nt", 32'(chr_we_a[1]), 32'h0);
    ppu_we = 1'b1; cfg_chr_ram = 1'b0; ppu_addr = 14'h0000;

    // Bus conflict behaviour on $8000+ and NINA register writes
    do_reset();
    prg_dat = 8'h05;
    bus_write(16'h8000, 8'h0F);
`ifdef BUS_CONFLICT_EN
    ss_chk(0, 8'd0, 8'h05, "bus conflict bx");
`else
    ss_chk(0, 8'd0, 8'h0F, "no bus conflict bx");
`endif
    bus_write(16'h7FFE, 8'h0F);
    ss_chk(1, 8'd1, 8'h0F, "nina no conflict");
    prg_dat = 8'hFF;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
